// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle RV32I-subset core: FSM states, ALU
// commands, opcodes and datapath select codes.
package cpu_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU command decoder; flags funct3 values the core does not
// implement so the FSM can trap.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control,
    output logic       dec_illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        dec_illegal = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type sub from addi, whose bit 30 is immediate
                    3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle core: sequences fetch/decode/execute and
// drives every datapath select and enable combinationally from the state.
module multicycle_controller #(
    parameter logic RESET_PC_WRITE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal
);
    import cpu_pkg::*;

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic [2:0] dec_alu;
    logic       dec_illegal;

    assign alu_op = (state_q == EXECR || state_q == EXECI) ? ALUOP_FUNCT : ALUOP_ADD;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (dec_alu),
        .dec_illegal (dec_illegal)
    );

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        imm_src     = IMM_I;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                // branch target precomputed here so BEQ only has to compare
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BEQ:            state_d = BEQ;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                if (op == OP_STORE) begin
                    imm_src = IMM_S;
                    state_d = MEMWRITE;
                end else begin
                    state_d = MEMREAD;
                end
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = mem_ready;
                if (mem_ready) state_d = FETCH;
            end
            EXECR: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = dec_alu;
                state_d     = dec_illegal ? TRAP : ALUWB;
            end
            EXECI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                imm_src     = IMM_I;
                alu_control = dec_alu;
                state_d     = dec_illegal ? TRAP : ALUWB;
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            BEQ: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = ALU_SUB;
                pc_write    = zero;
                state_d     = FETCH;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = TRAP;
        endcase
        // state is already FETCH under reset; only the enables need masking
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            pc_write  = RESET_PC_WRITE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench: each instruction is expanded into its expected
// per-cycle control vectors; a monitor compares them on the falling edge.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
        logic       illegal;
    } outs_t;

    typedef struct {
        string tag;
        outs_t e;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int    ntests = 0;
    int    nfail  = 0;
    int    ncyc   = 0;
    sb_t   sb_q[$];
    outs_t act;

    always #5 clk = ~clk;

    multicycle_controller #(.RESET_PC_WRITE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
        .illegal(illegal)
    );

    assign act = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
                  result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal};

    always @(negedge clk) begin
        ncyc++;
        if (sb_q.size() > 0) begin
            sb_t s;
            s = sb_q.pop_front();
            ntests++;
            if (act !== s.e) begin
                nfail++;
                $display("FAIL %s cyc=%0d got=%b required=%b (req,adr,mw,ir,pc,rw,res,a,b,imm,alu,ill)",
                         s.tag, ncyc, act, s.e);
            end
        end
    end

    // ---------------- reference model: expected vectors per phase ----------------
    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t o_fetch(bit rdy);
        outs_t o = '0;
        o.mem_req = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
        o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction

    function automatic outs_t o_reset();
        outs_t o = o_fetch(1'b0);
        o.mem_req = 1'b0;
        return o;
    endfunction

    function automatic outs_t o_decode();
        outs_t o = '0;
        o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; o.imm_src = 2'b10;
        return o;
    endfunction

    function automatic outs_t o_memadr(bit is_sw);
        outs_t o = '0;
        o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.imm_src = is_sw ? 2'b01 : 2'b00;
        return o;
    endfunction

    function automatic outs_t o_mem(bit is_sw, bit rdy);
        outs_t o = '0;
        o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_write = is_sw & rdy;
        return o;
    endfunction

    function automatic outs_t o_wb(bit from_mem);
        outs_t o = '0;
        o.reg_write = 1'b1; o.result_src = from_mem ? 2'b01 : 2'b00;
        return o;
    endfunction

    function automatic outs_t o_exec(bit is_r, logic [2:0] alu);
        outs_t o = '0;
        o.alu_src_a = 2'b10; o.alu_src_b = is_r ? 2'b00 : 2'b01; o.alu_control = alu;
        return o;
    endfunction

    function automatic outs_t o_beq(bit z);
        outs_t o = '0;
        o.alu_src_a = 2'b10; o.alu_control = 3'b001; o.pc_write = z;
        return o;
    endfunction

    function automatic outs_t o_jal();
        outs_t o = '0;
        o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_trap();
        outs_t o = '0;
        o.illegal = 1'b1;
        return o;
    endfunction

    // ALU command by instruction meaning: add/sub, slt(i), or(i), and(i)
    function automatic logic [2:0] exp_alu(bit is_r, logic [2:0] f3, bit f7, output bit ill);
        ill = 1'b0;
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: begin ill = 1'b1; return 3'b000; end
        endcase
    endfunction

    // one cycle: drive inputs just after the edge, queue what the monitor must see
    task automatic step(string tag, bit rst, bit rdy, bit z, outs_t e);
        sb_t s;
        @(posedge clk);
        #1;
        rst_n = rst; mem_ready = rdy; zero = z;
        s.tag = tag; s.e = e;
        sb_q.push_back(s);
    endtask

    task automatic plan_trap();
        for (int i = 0; i < 10; i++) step("trap", 1'b1, rb(), rb(), o_trap());
        step("trap_rst", 1'b0, 1'b1, rb(), o_reset());
        step("trap_rst", 1'b0, rb(), rb(), o_reset());
    endtask

    task automatic plan_instr(logic [6:0] o, logic [2:0] f3, bit f7, int wf, int wm, bit z);
        bit          ill;
        logic [2:0]  alu;
        bit          sw;
        op = o; funct3 = f3; funct7b5 = f7;
        for (int i = 0; i < wf; i++) step("fetch_wait", 1'b1, 1'b0, rb(), o_fetch(1'b0));
        step("fetch", 1'b1, 1'b1, rb(), o_fetch(1'b1));
        step("decode", 1'b1, rb(), rb(), o_decode());
        case (o)
            7'b0000011, 7'b0100011: begin
                sw = (o == 7'b0100011);
                step("memadr", 1'b1, rb(), rb(), o_memadr(sw));
                for (int i = 0; i < wm; i++) step("mem_wait", 1'b1, 1'b0, rb(), o_mem(sw, 1'b0));
                step("mem", 1'b1, 1'b1, rb(), o_mem(sw, 1'b1));
                if (!sw) step("memwb", 1'b1, rb(), rb(), o_wb(1'b1));
            end
            7'b0110011, 7'b0010011: begin
                alu = exp_alu(o == 7'b0110011, f3, f7, ill);
                step("exec", 1'b1, rb(), rb(), o_exec(o == 7'b0110011, alu));
                if (ill) plan_trap();
                else     step("aluwb", 1'b1, rb(), rb(), o_wb(1'b0));
            end
            7'b1100011: step("beq", 1'b1, rb(), z, o_beq(z));
            7'b1101111: begin
                step("jal", 1'b1, rb(), rb(), o_jal());
                step("jal_link", 1'b1, rb(), rb(), o_wb(1'b0));
            end
            default: plan_trap();
        endcase
    endtask

    // store whose write is cut off by reset while waiting on memory
    task automatic plan_sw_abort();
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        step("fetch", 1'b1, 1'b1, rb(), o_fetch(1'b1));
        step("decode", 1'b1, 1'b0, rb(), o_decode());
        step("memadr", 1'b1, 1'b0, rb(), o_memadr(1'b1));
        step("sw_wait", 1'b1, 1'b0, rb(), o_mem(1'b1, 1'b0));
        step("sw_abort_rst", 1'b0, 1'b1, rb(), o_reset());
    endtask

    initial begin
        logic [6:0] ops[7];
        logic [2:0] f3s[4];
        int         k;
        logic [2:0] f3;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
        ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b1110011;
        f3s[0] = 3'b000; f3s[1] = 3'b010; f3s[2] = 3'b110; f3s[3] = 3'b111;

        step("reset", 1'b0, 1'b1, 1'b0, o_reset());
        step("reset", 1'b0, 1'b1, 1'b1, o_reset());
        plan_instr(7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0);  // sub
        plan_instr(7'b0000011, 3'b010, 1'b0, 0, 2, 1'b0);  // lw, 2 wait cycles
        plan_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1);  // beq taken
        plan_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0);  // beq not taken
        plan_instr(7'b0110011, 3'b001, 1'b0, 0, 0, 1'b0);  // sll: unsupported
        plan_sw_abort();
        plan_instr(7'b0010011, 3'b000, 1'b1, 1, 0, 1'b0);  // addi with bit30 set
        plan_instr(7'b1101111, 3'b000, 1'b0, 0, 0, 1'b0);  // jal

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 6);
            if (k == 6 && $urandom_range(0, 2) != 0) k = $urandom_range(0, 5);
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : f3s[$urandom_range(0, 3)];
            if ($urandom_range(0, 39) == 0) plan_sw_abort();
            else plan_instr(ops[k], f3, rb(), $urandom_range(0, 2), $urandom_range(0, 2), rb());
        end

        repeat (3) @(posedge clk);
        ntests++;
        if (sb_q.size() != 0) begin
            nfail++;
            $display("FAIL sb_drain left=%0d required=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
